// File: rtl/tlp_transmitter_if.sv
// -----------------------------------------------------------------------------
// tlp_transmitter_if
// TLP source handshake bundle feeding the byte-serial TLP framer.
//
// Signals:
//   tlp_valid  source -> framer  a TLP is present on tlp_data
//   tlp_ready  framer -> source  framer accepts a TLP on this edge
//   tlp_data   source -> framer  8*N_BYTES bits, byte k = tlp_data[8k+7:8k]
//
// Modports:
//   master  the TLP source
//   slave   the framer (tlp_transmitter)
// -----------------------------------------------------------------------------
interface tlp_transmitter_if #(
    parameter int N_BYTES = 20
);
    logic                   tlp_valid;
    logic                   tlp_ready;
    logic [8*N_BYTES-1:0]   tlp_data;

    modport master (
        output tlp_valid,
        output tlp_data,
        input  tlp_ready
    );

    modport slave (
        input  tlp_valid,
        input  tlp_data,
        output tlp_ready
    );
endinterface

// File: rtl/tlp_transmitter.sv
// -----------------------------------------------------------------------------
// tlp_transmitter
// Byte-serial TLP framer. Takes one N_BYTES-byte TLP per valid/ready handshake
// and emits STP (FB, K=1), the payload bytes LSB-first (K=0) and END (FD, K=1)
// on an 8-bit symbol lane, followed by MIN_GAP idle symbols.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   tlp        slave modport of tlp_transmitter_if (tlp_valid/tlp_ready/tlp_data)
//   tx_enable  in   permits starting a new frame
//   data_out   out  registered symbol lane
//   datak      out  registered K-flag, 1 = control symbol on data_out
//   busy       out  high from the accept edge until the edge that emits END
//   tlp_count  out  frames fully transmitted, wraps 255 -> 0
// -----------------------------------------------------------------------------
module tlp_transmitter #(
    parameter int         N_BYTES  = 20,
    parameter int         MIN_GAP  = 1,
    parameter logic [7:0] IDLE_SYM = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    tlp_transmitter_if.slave tlp,
    input  logic             tx_enable,
    output logic [7:0]       data_out,
    output logic             datak,
    output logic             busy,
    output logic [7:0]       tlp_count
);
    localparam logic [7:0] STP_SYM = 8'hFB;
    localparam logic [7:0] END_SYM = 8'hFD;

    localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_END,
        S_GAP
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     byte_idx;
    logic [GAP_W-1:0]     gap_cnt;
    logic [8*N_BYTES-1:0] shreg;
    logic                 offer;

    // A TLP is taken whenever the source offers one while idle and enabled.
    // reset only gates the externally visible ready; inside the clocked
    // logic the async reset already dominates.
    assign offer         = tlp.tlp_valid && tx_enable;
    assign tlp.tlp_ready = (state == S_IDLE) && tx_enable && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            data_out  <= IDLE_SYM;
            datak     <= 1'b0;
            busy      <= 1'b0;
            tlp_count <= 8'd0;
            byte_idx  <= '0;
            gap_cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (offer) begin
                        data_out <= STP_SYM;
                        datak    <= 1'b1;
                        busy     <= 1'b1;
                        byte_idx <= '0;
                        state    <= S_PAYLOAD;
                    end else begin
                        data_out <= IDLE_SYM;
                        datak    <= 1'b0;
                    end
                end

                S_PAYLOAD: begin
                    // Payload bytes that look like FB/FD still go out as data.
                    data_out <= shreg[7:0];
                    datak    <= 1'b0;
                    byte_idx <= byte_idx + IDX_W'(1);
                    if (byte_idx == LAST_IDX) begin
                        state <= S_END;
                    end
                end

                S_END: begin
                    data_out  <= END_SYM;
                    datak     <= 1'b1;
                    busy      <= 1'b0;
                    tlp_count <= tlp_count + 8'd1;
                    gap_cnt   <= '0;
                    state     <= (MIN_GAP > 0) ? S_GAP : S_IDLE;
                end

                S_GAP: begin
                    data_out <= IDLE_SYM;
                    datak    <= 1'b0;
                    gap_cnt  <= gap_cnt + GAP_W'(1);
                    if (gap_cnt == LAST_GAP) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Payload shift register: captured only at the accept edge so later
    // changes on tlp_data never reach a frame in flight. Pure datapath, no reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && offer) begin
            shreg <= tlp.tlp_data;
        end else if (state == S_PAYLOAD) begin
            shreg <= shreg >> 8;
        end
    end
endmodule

// File: tb/tb_tlp_transmitter.sv
// -----------------------------------------------------------------------------
// tb_tlp_transmitter
// Two framers share one stimulus stream: inst[0] uses MIN_GAP=1, inst[1] uses
// MIN_GAP=0. For each instance a frame-level model predicts when a TLP is
// accepted and queues the expected frame with its start time; a monitor pops
// frames at their start time and compares every lane symbol, K-flag, busy and
// tlp_count against the expected stream.
// -----------------------------------------------------------------------------
module tb_tlp_transmitter;
    localparam int         N_BYTES = 20;
    localparam int         TLP_W   = 8 * N_BYTES;
    localparam logic [7:0] IDLE    = 8'h00;

    typedef struct {
        int               start;
        logic [TLP_W-1:0] data;
    } frame_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             tv;
    logic [TLP_W-1:0] td;
    logic             tx_en;
    int               edge_n   = 0;
    int               checks   = 0;
    int               failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
        end
    endtask

    function automatic logic [TLP_W-1:0] rand_tlp();
        logic [TLP_W-1:0] v;
        v = '0;
        for (int b = 0; b < N_BYTES; b++) begin
            case ($urandom_range(0, 7))
                0:       v[8*b +: 8] = 8'hFB;
                1:       v[8*b +: 8] = 8'hFD;
                default: v[8*b +: 8] = 8'($urandom);
            endcase
        end
        return v;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int GAP = (g == 0) ? 1 : 0;

        tlp_transmitter_if #(.N_BYTES(N_BYTES)) bus ();
        logic [7:0] dout;
        logic       k;
        logic       bsy;
        logic [7:0] cnt;

        assign bus.tlp_valid = tv;
        assign bus.tlp_data  = td;

        tlp_transmitter #(
            .N_BYTES (N_BYTES),
            .MIN_GAP (GAP),
            .IDLE_SYM(IDLE)
        ) dut (
            .clk      (clk),
            .reset    (reset),
            .tlp      (bus),
            .tx_enable(tx_en),
            .data_out (dout),
            .datak    (k),
            .busy     (bsy),
            .tlp_count(cnt)
        );

        frame_t           q[$];
        int               next_ok      = 0;
        int               last_start   = -1;
        int               hs_since_rst = 0;
        logic [7:0]       exp_cnt      = 8'd0;
        bit               in_frame     = 1'b0;
        int               pos          = 0;
        logic [TLP_W-1:0] cur          = '0;

        // Model: a TLP is accepted at the next edge when the framer is free
        // (a frame occupies N_BYTES+2 symbols plus GAP idles) and enabled.
        always @(negedge clk) begin
            bit     exp_rdy;
            frame_t f;
            exp_rdy = !reset && tx_en && (edge_n + 1 >= next_ok);
            chk($sformatf("g%0d tlp_ready", g), 32'(bus.tlp_ready), 32'(exp_rdy));
            if (reset) begin
                next_ok      = 0;
                hs_since_rst = 0;
            end else if (exp_rdy && tv) begin
                f.start = edge_n + 1;
                f.data  = td;
                q.push_back(f);
                last_start = f.start;
                hs_since_rst++;
                next_ok = f.start + N_BYTES + 2 + GAP;
            end
        end

        // Monitor: expected lane is idle unless a queued frame is due or running.
        always @(negedge clk) begin
            logic [7:0] e_sym;
            logic       e_k;
            logic       e_busy;
            frame_t     f;
            e_sym  = IDLE;
            e_k    = 1'b0;
            e_busy = 1'b0;
            if (reset) begin
                q.delete();
                in_frame = 1'b0;
                exp_cnt  = 8'd0;
            end else if (in_frame) begin
                pos++;
                if (pos <= N_BYTES) begin
                    e_sym  = cur[8*(pos-1) +: 8];
                    e_busy = 1'b1;
                end else begin
                    e_sym    = 8'hFD;
                    e_k      = 1'b1;
                    exp_cnt  = exp_cnt + 8'd1;
                    in_frame = 1'b0;
                end
            end else if (q.size() > 0 && q[0].start == edge_n) begin
                f        = q.pop_front();
                cur      = f.data;
                in_frame = 1'b1;
                pos      = 0;
                e_sym    = 8'hFB;
                e_k      = 1'b1;
                e_busy   = 1'b1;
            end
            chk($sformatf("g%0d data_out", g), 32'(dout), 32'(e_sym));
            chk($sformatf("g%0d datak", g), 32'(k), 32'(e_k));
            chk($sformatf("g%0d busy", g), 32'(bsy), 32'(e_busy));
            chk($sformatf("g%0d tlp_count", g), 32'(cnt), 32'(exp_cnt));
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_start0(input string name);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (inst[0].last_start == edge_n) begin
                checks++;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL %s: no STP within 200 cycles, expected one", name);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " g0 data_out"}, 32'(inst[0].dout), 32'(IDLE));
        chk({tag, " g0 datak"}, 32'(inst[0].k), 32'd0);
        chk({tag, " g0 busy"}, 32'(inst[0].bsy), 32'd0);
        chk({tag, " g0 tlp_count"}, 32'(inst[0].cnt), 32'd0);
        chk({tag, " g0 tlp_ready"}, 32'(inst[0].bus.tlp_ready), 32'd0);
        chk({tag, " g1 data_out"}, 32'(inst[1].dout), 32'(IDLE));
        chk({tag, " g1 datak"}, 32'(inst[1].k), 32'd0);
        chk({tag, " g1 busy"}, 32'(inst[1].bsy), 32'd0);
        chk({tag, " g1 tlp_count"}, 32'(inst[1].cnt), 32'd0);
        chk({tag, " g1 tlp_ready"}, 32'(inst[1].bus.tlp_ready), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        int nst0, nst1, p0, p1, rdy;
        int nk, nr;

        reset = 1'b0;
        tv    = 1'b0;
        td    = '0;
        tx_en = 1'b0;
        #1 reset = 1'b1;
        #1 chk_idle("reset");
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Single TLP with bytes 10..23
        tx_en = 1'b1;
        for (int b = 0; b < N_BYTES; b++) td[8*b +: 8] = 8'(8'h10 + b);
        tv = 1'b1;
        wait_start0("t1 start");
        tv = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 30; c++) begin
            if (inst[0].bsy) busy_cycles++;
            step(1);
        end
        chk("t1 busy cycles", 32'(busy_cycles), 32'd21);
        chk("t1 g0 count", 32'(inst[0].cnt), 32'd1);
        chk("t1 g1 count", 32'(inst[1].cnt), 32'd1);

        // valid held high, data changing every cycle
        tv = 1'b1;
        td = rand_tlp();
        nst0 = 0; nst1 = 0; p0 = 0; p1 = 0; rdy = 0;
        for (int c = 0; c < 150 && nst0 < 3; c++) begin
            step(1);
            if (nst0 >= 1 && inst[0].bus.tlp_ready) rdy++;
            if (inst[0].last_start == edge_n) begin
                if (nst0 > 0) chk("t2 g0 stp period", 32'(edge_n - p0), 32'd23);
                p0 = edge_n;
                nst0++;
            end
            if (inst[1].last_start == edge_n) begin
                if (nst1 > 0) chk("t3 g1 stp period", 32'(edge_n - p1), 32'd22);
                p1 = edge_n;
                nst1++;
            end
            td = rand_tlp();
        end
        tv = 1'b0;
        chk("t2 g0 starts", 32'(nst0), 32'd3);
        chk("t2 ready pulses", 32'(rdy), 32'd2);
        step(30);
        chk("t2 g0 count", 32'(inst[0].cnt), 32'd4);

        // tx_enable dropped after payload byte 5
        tv = 1'b1;
        wait_start0("t4 start");
        step(6);
        tx_en = 1'b0;
        nk = 0; nr = 0;
        for (int c = 0; c < 50; c++) begin
            step(1);
            td = rand_tlp();
            if (inst[0].k) nk++;
            if (inst[0].bus.tlp_ready) nr++;
        end
        chk("t4 g0 k symbols", 32'(nk), 32'd1);
        chk("t4 g0 ready cycles", 32'(nr), 32'd0);
        chk("t4 g0 count", 32'(inst[0].cnt), 32'd5);
        tx_en = 1'b1;
        wait_start0("t4 resume");
        tv = 1'b0;

        // reset during payload byte 10 of the next frame; it clears the
        // counter and the aborted frame adds nothing
        step(30);
        tv = 1'b1;
        wait_start0("t5 start");
        tv = 1'b0;
        step(11);
        reset = 1'b1;
        #1 chk_idle("t5 reset");
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        tv = 1'b1;
        td = rand_tlp();
        wait_start0("t5 restart");
        tv = 1'b0;
        step(30);
        chk("t5 g0 count", 32'(inst[0].cnt), 32'd1);

        // random traffic until 257 TLPs since reset, FB/FD bytes in payloads
        for (int c = 0; c < 20000 && inst[0].hs_since_rst < 257; c++) begin
            step(1);
            tv    = ($urandom_range(0, 3) != 0);
            tx_en = ($urandom_range(0, 15) != 0);
            td    = rand_tlp();
        end
        tv    = 1'b0;
        tx_en = 1'b1;
        step(40);
        chk("t6 g0 accepted", 32'(inst[0].hs_since_rst), 32'd257);
        chk("t6 g0 count wrap", 32'(inst[0].cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
